// File: rtl/reservation_station_if.sv
// Shared widths, control bundle type and the CDB broadcast interface
// used by the reservation station and its neighbours.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

package rs_pkg;
    typedef enum logic {
        src_reg2 = 1'b0,
        src_imm  = 1'b1
    } alu_src_t;

    typedef enum logic [2:0] {
        add_op, sub_op, and_op, or_op,
        xor_op, sll_op, srl_op, slt_op
    } alu_op_t;

    typedef enum logic [1:0] {
        no_mem_op = 2'd0,
        load_op   = 2'd1,
        store_op  = 2'd2
    } mem_op_t;

    typedef struct packed {
        alu_src_t alu_src;
        alu_op_t  alu_op;
        logic     is_branch_op;
        mem_op_t  memory_op;
        logic     reg_wb;
    } control_t;

    localparam control_t CTRL_NOP = '{
        alu_src:      src_reg2,
        alu_op:       add_op,
        is_branch_op: 1'b0,
        memory_op:    no_mem_op,
        reg_wb:       1'b0
    };
endpackage

interface CDB_IF;
    logic                               valid;
    logic [`PHYSICAL_REG_NUM_WIDTH-1:0] register_addr;
    logic [`REG_VAL_WIDTH-1:0]          register_val;

    modport master (
        output valid,
        output register_addr,
        output register_val
    );

    modport slave (
        input valid,
        input register_addr,
        input register_val
    );
endinterface

// File: rtl/reservation_station.sv
// Unified collapsing issue queue with a physical-register scoreboard,
// CDB wakeup and an oldest-ready-first registered issue port.
`ifndef REG_VAL_WIDTH
`define REG_VAL_WIDTH 32
`endif
`ifndef PHYSICAL_REG_NUM_WIDTH
`define PHYSICAL_REG_NUM_WIDTH 6
`endif
`ifndef INST_ADDR_WIDTH
`define INST_ADDR_WIDTH 32
`endif
`ifndef ROB_SIZE_WIDTH
`define ROB_SIZE_WIDTH 4
`endif

module reservation_station
    import rs_pkg::*;
#(
    parameter int RS_DEPTH = 4,
    parameter int GENERATED_IMMEDIATE_WIDTH = `REG_VAL_WIDTH,
    parameter int PHY_REG_NUM = 2**`PHYSICAL_REG_NUM_WIDTH
) (
    input  logic clk,
    input  logic reset,
    input  logic valid_inst_in,
    input  logic [`REG_VAL_WIDTH-1:0] src_val1_in,
    input  logic [`REG_VAL_WIDTH-1:0] src_val2_in,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] src_phy_reg1_in,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] src_phy_reg2_in,
    input  logic [`PHYSICAL_REG_NUM_WIDTH-1:0] dst_phy_reg_in,
    input  control_t control_in,
    input  logic [`INST_ADDR_WIDTH-1:0] pc_in,
    input  logic [GENERATED_IMMEDIATE_WIDTH-1:0] generated_immediate_in,
    input  logic [`ROB_SIZE_WIDTH-1:0] inst_tag_in,
    input  logic flush,
    CDB_IF.slave CDB_if,
    input  logic exec_ready,
    output logic stall_out,
    output logic issue_valid,
    output logic [`REG_VAL_WIDTH-1:0] issue_src_val1,
    output logic [`REG_VAL_WIDTH-1:0] issue_src_val2,
    output logic [`PHYSICAL_REG_NUM_WIDTH-1:0] issue_dst_phy_reg,
    output control_t issue_control,
    output logic [`INST_ADDR_WIDTH-1:0] issue_pc,
    output logic [GENERATED_IMMEDIATE_WIDTH-1:0] issue_immediate,
    output logic [`ROB_SIZE_WIDTH-1:0] issue_inst_tag,
    output logic [$clog2(RS_DEPTH+1)-1:0] occupancy,
    output logic overflow_err
);

    localparam int OCC_W = $clog2(RS_DEPTH+1);
    localparam int IDX_W = $clog2(RS_DEPTH);

    typedef logic [`PHYSICAL_REG_NUM_WIDTH-1:0] tag_t;
    typedef logic [`REG_VAL_WIDTH-1:0] val_t;

    typedef struct packed {
        val_t     val1;
        val_t     val2;
        tag_t     dst;
        control_t ctrl;
        logic [`INST_ADDR_WIDTH-1:0] pc;
        logic [GENERATED_IMMEDIATE_WIDTH-1:0] imm;
        logic [`ROB_SIZE_WIDTH-1:0] itag;
    } issue_t;

    typedef struct packed {
        logic   valid;
        logic   rdy1;
        logic   rdy2;
        tag_t   tag1;
        tag_t   tag2;
        issue_t p;
    } entry_t;

    entry_t ent_q [RS_DEPTH];
    entry_t ent_d [RS_DEPTH];
    entry_t woken [RS_DEPTH];
    entry_t new_ent;

    logic [PHY_REG_NUM-1:0] sb_q, sb_d;
    logic [OCC_W-1:0] occ_q, occ_d, occ_after;
    logic ovf_q, ovf_d;
    logic iss_valid_q, iss_valid_d;
    issue_t iss_q, iss_d;

    logic sel_found, load, remove, enq_ok;
    logic hit1, hit2;
    logic [IDX_W-1:0] sel_idx;

    // Oldest (lowest index) entry with both operands ready
    always_comb begin
        sel_found = 1'b0;
        sel_idx = '0;
        for (int i = RS_DEPTH-1; i >= 0; i--) begin
            if (ent_q[i].valid && ent_q[i].rdy1 && ent_q[i].rdy2) begin
                sel_found = 1'b1;
                sel_idx = IDX_W'(i);
            end
        end
    end

    assign load = ~iss_valid_q | exec_ready;
    assign remove = load & sel_found;
    assign occ_after = occ_q - OCC_W'(remove);
    assign enq_ok = valid_inst_in && (occ_after < OCC_W'(RS_DEPTH));

    // CDB wakeup of pending operands in held entries
    always_comb begin
        for (int i = 0; i < RS_DEPTH; i++) begin
            woken[i] = ent_q[i];
            if (CDB_if.valid && ent_q[i].valid) begin
                if (!ent_q[i].rdy1 && ent_q[i].tag1 == CDB_if.register_addr) begin
                    woken[i].rdy1 = 1'b1;
                    woken[i].p.val1 = CDB_if.register_val;
                end
                if (!ent_q[i].rdy2 && ent_q[i].tag2 == CDB_if.register_addr) begin
                    woken[i].rdy2 = 1'b1;
                    woken[i].p.val2 = CDB_if.register_val;
                end
            end
        end
    end

    // Incoming entry: scoreboard, same-cycle CDB bypass, unused src2
    always_comb begin
        hit1 = CDB_if.valid && (CDB_if.register_addr == src_phy_reg1_in);
        hit2 = CDB_if.valid && (CDB_if.register_addr == src_phy_reg2_in);
        new_ent.valid = 1'b1;
        new_ent.tag1 = src_phy_reg1_in;
        new_ent.tag2 = src_phy_reg2_in;
        new_ent.rdy1 = sb_q[src_phy_reg1_in] | hit1;
        new_ent.rdy2 = sb_q[src_phy_reg2_in] | hit2
                     | (control_in.alu_src != src_reg2);
        new_ent.p.val1 = hit1 ? CDB_if.register_val : src_val1_in;
        new_ent.p.val2 = hit2 ? CDB_if.register_val : src_val2_in;
        new_ent.p.dst = dst_phy_reg_in;
        new_ent.p.ctrl = control_in;
        new_ent.p.pc = pc_in;
        new_ent.p.imm = generated_immediate_in;
        new_ent.p.itag = inst_tag_in;
    end

    // Collapse over the removed slot, then append at the tail
    always_comb begin
        for (int i = 0; i < RS_DEPTH-1; i++) begin
            if (remove && i >= int'(sel_idx))
                ent_d[i] = woken[i+1];
            else
                ent_d[i] = woken[i];
        end
        ent_d[RS_DEPTH-1] = remove ? '0 : woken[RS_DEPTH-1];
        if (enq_ok) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (occ_after == OCC_W'(i))
                    ent_d[i] = new_ent;
            end
        end
        occ_d = occ_after + OCC_W'(enq_ok);
        ovf_d = ovf_q | (valid_inst_in & ~enq_ok);
    end

    // Scoreboard: CDB sets, accepted writer clears (clear wins)
    always_comb begin
        sb_d = sb_q;
        if (CDB_if.valid)
            sb_d[CDB_if.register_addr] = 1'b1;
        if (enq_ok && control_in.reg_wb && dst_phy_reg_in != '0)
            sb_d[dst_phy_reg_in] = 1'b0;
        sb_d[0] = 1'b1;
    end

    // Issue register next state; holds while stalled downstream
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_d = iss_q;
        if (load) begin
            iss_valid_d = sel_found;
            if (sel_found)
                iss_d = ent_q[sel_idx].p;
        end
    end

    // State update with reset, then flush, taking priority
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < RS_DEPTH; i++)
                ent_q[i] <= '0;
            occ_q <= '0;
            sb_q <= '1;
            ovf_q <= 1'b0;
            iss_valid_q <= 1'b0;
            iss_q <= '0;
            iss_q.ctrl <= CTRL_NOP;
        end else if (flush) begin
            for (int i = 0; i < RS_DEPTH; i++)
                ent_q[i] <= '0;
            occ_q <= '0;
            sb_q <= '1;
            iss_valid_q <= 1'b0;
            iss_q <= '0;
            iss_q.ctrl <= CTRL_NOP;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++)
                ent_q[i] <= ent_d[i];
            occ_q <= occ_d;
            sb_q <= sb_d;
            ovf_q <= ovf_d;
            iss_valid_q <= iss_valid_d;
            iss_q <= iss_d;
        end
    end

    assign stall_out = occ_q >= OCC_W'(RS_DEPTH-1);
    assign occupancy = occ_q;
    assign overflow_err = ovf_q;
    assign issue_valid = iss_valid_q;
    assign issue_src_val1 = iss_q.val1;
    assign issue_src_val2 = iss_q.val2;
    assign issue_dst_phy_reg = iss_q.dst;
    assign issue_control = iss_q.ctrl;
    assign issue_pc = iss_q.pc;
    assign issue_immediate = iss_q.imm;
    assign issue_inst_tag = iss_q.itag;

endmodule

// File: tb/tb_reservation_station.sv
// Directed bench for reservation_station with a queue-level
// reference model compared every cycle plus literal expectations.
module tb_reservation_station;
    import rs_pkg::*;

    localparam int D  = 4;
    localparam int TW = `PHYSICAL_REG_NUM_WIDTH;
    localparam int VW = `REG_VAL_WIDTH;
    localparam int AW = `INST_ADDR_WIDTH;
    localparam int RW = `ROB_SIZE_WIDTH;

    localparam control_t C_ADD = CTRL_NOP;
    localparam control_t C_WB = '{alu_src: src_reg2, alu_op: add_op,
        is_branch_op: 1'b0, memory_op: no_mem_op, reg_wb: 1'b1};
    localparam control_t C_IMM = '{alu_src: src_imm, alu_op: sub_op,
        is_branch_op: 1'b0, memory_op: no_mem_op, reg_wb: 1'b1};
    localparam control_t C_LD = '{alu_src: src_imm, alu_op: add_op,
        is_branch_op: 1'b0, memory_op: load_op, reg_wb: 1'b1};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic valid_inst_in = 1'b0;
    logic [VW-1:0] src_val1_in = '0, src_val2_in = '0;
    logic [TW-1:0] src_phy_reg1_in = '0, src_phy_reg2_in = '0;
    logic [TW-1:0] dst_phy_reg_in = '0;
    control_t control_in = CTRL_NOP;
    logic [AW-1:0] pc_in = '0;
    logic [VW-1:0] generated_immediate_in = '0;
    logic [RW-1:0] inst_tag_in = '0;
    logic flush = 1'b0;
    logic exec_ready = 1'b0;
    logic stall_out, issue_valid, overflow_err;
    logic [VW-1:0] issue_src_val1, issue_src_val2, issue_immediate;
    logic [TW-1:0] issue_dst_phy_reg;
    control_t issue_control;
    logic [AW-1:0] issue_pc;
    logic [RW-1:0] issue_inst_tag;
    logic [$clog2(D+1)-1:0] occupancy;

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    always #5 clk = ~clk;

    CDB_IF cdb();

    reservation_station #(.RS_DEPTH(D)) dut (
        .clk(clk),
        .reset(reset),
        .valid_inst_in(valid_inst_in),
        .src_val1_in(src_val1_in),
        .src_val2_in(src_val2_in),
        .src_phy_reg1_in(src_phy_reg1_in),
        .src_phy_reg2_in(src_phy_reg2_in),
        .dst_phy_reg_in(dst_phy_reg_in),
        .control_in(control_in),
        .pc_in(pc_in),
        .generated_immediate_in(generated_immediate_in),
        .inst_tag_in(inst_tag_in),
        .flush(flush),
        .CDB_if(cdb),
        .exec_ready(exec_ready),
        .stall_out(stall_out),
        .issue_valid(issue_valid),
        .issue_src_val1(issue_src_val1),
        .issue_src_val2(issue_src_val2),
        .issue_dst_phy_reg(issue_dst_phy_reg),
        .issue_control(issue_control),
        .issue_pc(issue_pc),
        .issue_immediate(issue_immediate),
        .issue_inst_tag(issue_inst_tag),
        .occupancy(occupancy),
        .overflow_err(overflow_err)
    );

    typedef struct packed {
        logic r1, r2;
        logic [TW-1:0] t1, t2;
        logic [VW-1:0] v1, v2;
        logic [TW-1:0] dst;
        control_t ctrl;
        logic [AW-1:0] pc;
        logic [VW-1:0] imm;
        logic [RW-1:0] tag;
    } m_ent_t;

    m_ent_t mq[$];
    m_ent_t m_iss = '0;
    m_ent_t m_e;
    bit m_iv = 0;
    bit m_ovf = 0;
    bit mrdy [64];
    int m_sel;
    bit m_load, m_h1, m_h2;

    task automatic chk(input string n, input logic [63:0] a,
                       input logic [63:0] e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h t=%0t", n, a, e, $time);
        end
    endtask

    // Reference model: list of held instructions in age order
    always @(posedge clk) begin
        if (!reset) begin
            mq.delete();
            m_iv = 0;
            m_iss = '0;
            m_ovf = 0;
            foreach (mrdy[i]) mrdy[i] = 1;
        end else if (flush) begin
            mq.delete();
            m_iv = 0;
            m_iss.ctrl = CTRL_NOP;
            foreach (mrdy[i]) mrdy[i] = 1;
        end else begin
            m_load = !m_iv || exec_ready;
            m_sel = -1;
            foreach (mq[i])
                if (m_sel < 0 && mq[i].r1 && mq[i].r2) m_sel = i;
            if (cdb.valid) begin
                foreach (mq[i]) begin
                    m_e = mq[i];
                    if (!m_e.r1 && m_e.t1 == cdb.register_addr) begin
                        m_e.r1 = 1;
                        m_e.v1 = cdb.register_val;
                    end
                    if (!m_e.r2 && m_e.t2 == cdb.register_addr) begin
                        m_e.r2 = 1;
                        m_e.v2 = cdb.register_val;
                    end
                    mq[i] = m_e;
                end
            end
            if (m_load) begin
                if (m_sel >= 0) begin
                    m_iss = mq[m_sel];
                    m_iv = 1;
                    mq.delete(m_sel);
                end else begin
                    m_iv = 0;
                end
            end
            if (valid_inst_in) begin
                if (mq.size() < D) begin
                    m_h1 = cdb.valid && cdb.register_addr == src_phy_reg1_in;
                    m_h2 = cdb.valid && cdb.register_addr == src_phy_reg2_in;
                    m_e.t1 = src_phy_reg1_in;
                    m_e.t2 = src_phy_reg2_in;
                    m_e.r1 = mrdy[src_phy_reg1_in] || m_h1;
                    m_e.r2 = mrdy[src_phy_reg2_in] || m_h2 ||
                             control_in.alu_src == src_imm;
                    m_e.v1 = m_h1 ? cdb.register_val : src_val1_in;
                    m_e.v2 = m_h2 ? cdb.register_val : src_val2_in;
                    m_e.dst = dst_phy_reg_in;
                    m_e.ctrl = control_in;
                    m_e.pc = pc_in;
                    m_e.imm = generated_immediate_in;
                    m_e.tag = inst_tag_in;
                    mq.push_back(m_e);
                    if (cdb.valid) mrdy[cdb.register_addr] = 1;
                    if (control_in.reg_wb && dst_phy_reg_in != 0)
                        mrdy[dst_phy_reg_in] = 0;
                end else begin
                    m_ovf = 1;
                    if (cdb.valid) mrdy[cdb.register_addr] = 1;
                end
            end else if (cdb.valid) begin
                mrdy[cdb.register_addr] = 1;
            end
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (chk_en) begin
            chk("occupancy", 64'(occupancy), 64'(mq.size()));
            chk("stall_out", 64'(stall_out), 64'(mq.size() >= D-1));
            chk("overflow_err", 64'(overflow_err), 64'(m_ovf));
            chk("issue_valid", 64'(issue_valid), 64'(m_iv));
            chk("issue_control", 64'(issue_control), 64'(m_iss.ctrl));
            if (m_iv) begin
                chk("issue_src_val1", 64'(issue_src_val1), 64'(m_iss.v1));
                chk("issue_src_val2", 64'(issue_src_val2), 64'(m_iss.v2));
                chk("issue_dst", 64'(issue_dst_phy_reg), 64'(m_iss.dst));
                chk("issue_pc", 64'(issue_pc), 64'(m_iss.pc));
                chk("issue_imm", 64'(issue_immediate), 64'(m_iss.imm));
                chk("issue_tag", 64'(issue_inst_tag), 64'(m_iss.tag));
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        valid_inst_in = 0;
        cdb.valid = 0;
        flush = 0;
    endtask

    task automatic enq(input logic [RW-1:0] tag, input logic [TW-1:0] s1,
                       input logic [TW-1:0] s2, input logic [TW-1:0] d,
                       input logic [VW-1:0] v1, input logic [VW-1:0] v2,
                       input control_t c);
        valid_inst_in = 1;
        inst_tag_in = tag;
        src_phy_reg1_in = s1;
        src_phy_reg2_in = s2;
        dst_phy_reg_in = d;
        src_val1_in = v1;
        src_val2_in = v2;
        control_in = c;
        pc_in = 32'h1000 + 32'(tag) * 4;
        generated_immediate_in = 32'(tag) * 16 + 7;
    endtask

    task automatic bc(input logic [TW-1:0] r, input logic [VW-1:0] v);
        cdb.valid = 1;
        cdb.register_addr = r;
        cdb.register_val = v;
    endtask

    initial begin
        cdb.valid = 0;
        cdb.register_addr = '0;
        cdb.register_val = '0;
        cyc();
        chk_en = 1;
        cyc();
        chk("rst occ", 64'(occupancy), 0);
        chk("rst valid", 64'(issue_valid), 0);
        chk("rst ovf", 64'(overflow_err), 0);
        chk("rst val1", 64'(issue_src_val1), 0);
        chk("rst ctrl", 64'(issue_control), 0);
        chk("rst stall", 64'(stall_out), 0);
        reset = 1;

        exec_ready = 1;
        enq(0, 5, 6, 7, 3, 4, C_ADD);
        cyc();
        chk("t1 occ", 64'(occupancy), 1);
        chk("t1 pre valid", 64'(issue_valid), 0);
        cyc();
        chk("t1 valid", 64'(issue_valid), 1);
        chk("t1 val1", 64'(issue_src_val1), 3);
        chk("t1 val2", 64'(issue_src_val2), 4);
        chk("t1 occ0", 64'(occupancy), 0);

        enq(1, 1, 2, 9, 1, 2, C_WB);
        cyc();
        enq(2, 9, 3, 10, 32'hdead, 5, C_ADD);
        cyc();
        chk("t2 occ", 64'(occupancy), 1);
        cyc();
        bc(9, 32'h55);
        cyc();
        chk("t2 not yet", 64'(issue_valid), 0);
        cyc();
        chk("t2 valid", 64'(issue_valid), 1);
        chk("t2 tag", 64'(issue_inst_tag), 2);
        chk("t2 val1", 64'(issue_src_val1), 32'h55);

        enq(3, 0, 0, 9, 0, 0, C_WB);
        cyc();
        enq(4, 9, 0, 11, 32'h1111, 0, C_ADD);
        bc(9, 32'h77);
        cyc();
        chk("t3 occ", 64'(occupancy), 1);
        cyc();
        chk("t3 tag", 64'(issue_inst_tag), 4);
        chk("t3 val1", 64'(issue_src_val1), 32'h77);

        exec_ready = 0;
        for (int k = 0; k < 4; k++) begin
            enq(RW'(k), 0, 0, 0, 32'(k), 32'(k + 1), C_ADD);
            cyc();
            if (k == 1) chk("t4 stall@2", 64'(stall_out), 0);
            if (k == 2) chk("t4 stall@3", 64'(stall_out), 1);
        end
        chk("t4 full", 64'(occupancy), 4);
        enq(5, 0, 0, 0, 9, 9, C_ADD);
        cyc();
        chk("t4 ovf", 64'(overflow_err), 1);
        chk("t4 occ4", 64'(occupancy), 4);
        chk("t4 hold tag", 64'(issue_inst_tag), 4);
        chk("t4 hold val", 64'(issue_src_val1), 32'h77);
        exec_ready = 1;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("t4 order", 64'(issue_inst_tag), 64'(k));
            chk("t4 order val2", 64'(issue_src_val2), 64'(k + 1));
        end
        chk("t4 drained", 64'(occupancy), 0);
        cyc();
        chk("t4 idle", 64'(issue_valid), 0);

        enq(6, 0, 0, 12, 0, 0, C_WB);
        cyc();
        enq(7, 12, 0, 13, 32'h2222, 1, C_LD);
        cyc();
        enq(8, 0, 12, 14, 8, 32'h3333, C_IMM);
        cyc();
        cyc();
        chk("t5 young", 64'(issue_inst_tag), 8);
        chk("t5 young val2", 64'(issue_src_val2), 32'h3333);
        bc(12, 32'habc);
        cyc();
        chk("t5 gap", 64'(issue_valid), 0);
        chk("t5 occ", 64'(occupancy), 1);
        cyc();
        chk("t5 old", 64'(issue_inst_tag), 7);
        chk("t5 old val1", 64'(issue_src_val1), 32'habc);

        exec_ready = 0;
        enq(9, 0, 0, 20, 0, 0, C_WB);
        cyc();
        enq(10, 20, 0, 21, 32'h4444, 0, C_ADD);
        cyc();
        enq(11, 0, 0, 22, 1, 1, C_ADD);
        cyc();
        chk("t6 occ3", 64'(occupancy), 3);
        chk("t6 held ctrl", 64'(issue_control), 64'(C_LD));
        enq(12, 0, 0, 23, 2, 2, C_WB);
        flush = 1;
        cyc();
        chk("t6 occ0", 64'(occupancy), 0);
        chk("t6 valid", 64'(issue_valid), 0);
        chk("t6 nop", 64'(issue_control), 0);
        chk("t6 ovf kept", 64'(overflow_err), 1);
        exec_ready = 1;
        enq(13, 20, 0, 24, 32'h99, 0, C_ADD);
        cyc();
        chk("t6 occ1", 64'(occupancy), 1);
        cyc();
        chk("t6 tag", 64'(issue_inst_tag), 13);
        chk("t6 val1", 64'(issue_src_val1), 32'h99);
        cyc();
        cyc();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
